// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped read-only instruction cache; ICACHE_STATS_EN adds hit/miss counters
module inst_cache #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic        _if_req,
  input  logic [31:0] _if_pc,
  output logic        _if_ready,
  output logic [31:0] _if_inst,
  output logic        _mc_req,
  output logic [31:0] _mc_addr,
  input  logic        _mc_valid,
  input  logic [31:0] _mc_data,
  output logic [31:0] _hit_cnt,
  output logic [31:0] _miss_cnt
);

  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MISS,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];

  logic                  if_ready_q, if_ready_d;
  logic [31:0]           if_inst_q, if_inst_d;
  logic                  mc_req_q, mc_req_d;
  logic [29:0]           mc_word_q, mc_word_d;

  logic                  fill_en;
  logic                  hit_accept;
  logic                  miss_accept;

  // Fetch address split; the fill line comes from the outstanding miss address
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  hit;

  assign req_idx  = _if_pc[INDEX_BITS+1:2];
  assign req_tag  = _if_pc[31:INDEX_BITS+2];
  assign fill_idx = mc_word_q[INDEX_BITS-1:0];
  assign fill_tag = mc_word_q[29:INDEX_BITS];
  assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  // Byte offset of the fetch address is irrelevant for word fetches
  logic unused_pc_bits;
  assign unused_pc_bits = ^_if_pc[1:0];

  // Next-state and output logic; a flush wins over every transition but still lets a fill land
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    if_ready_d  = if_ready_q;
    if_inst_d   = if_inst_q;
    mc_req_d    = mc_req_q;
    mc_word_d   = mc_word_q;
    fill_en     = 1'b0;
    hit_accept  = 1'b0;
    miss_accept = 1'b0;

    if (state_q == S_MISS && _mc_valid) begin
      fill_en           = 1'b1;
      valid_d[fill_idx] = 1'b1;
    end

    if (_clear) begin
      state_d    = S_IDLE;
      if_ready_d = 1'b0;
      mc_req_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if_ready_d = 1'b0;
          if (_if_req) begin
            if (hit) begin
              if_ready_d = 1'b1;
              if_inst_d  = data_mem[req_idx];
              state_d    = S_RESP;
              hit_accept = 1'b1;
            end else begin
              mc_req_d    = 1'b1;
              mc_word_d   = _if_pc[31:2];
              state_d     = S_MISS;
              miss_accept = 1'b1;
            end
          end
        end
        S_MISS: begin
          if (_mc_valid) begin
            if_ready_d = 1'b1;
            if_inst_d  = _mc_data;
            mc_req_d   = 1'b0;
            state_d    = S_RESP;
          end
        end
        S_RESP: begin
          if_ready_d = 1'b0;
          state_d    = S_IDLE;
        end
        default: begin
          state_d    = S_IDLE;
          if_ready_d = 1'b0;
          mc_req_d   = 1'b0;
        end
      endcase
    end
  end

  // Control and output registers; everything freezes while rdy_in is low
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      if_ready_q <= 1'b0;
      if_inst_q  <= '0;
      mc_req_q   <= 1'b0;
      mc_word_q  <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      if_ready_q <= if_ready_d;
      if_inst_q  <= if_inst_d;
      mc_req_q   <= mc_req_d;
      mc_word_q  <= mc_word_d;
    end
  end

  // Tag and data arrays; contents are only meaningful where the valid bit is set
  always_ff @(posedge clk_in) begin
    if (rdy_in && fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= _mc_data;
    end
  end

  assign _if_ready = if_ready_q;
  assign _if_inst  = if_inst_q;
  assign _mc_req   = mc_req_q;
  assign _mc_addr  = {mc_word_q, 2'b00};

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Acceptance counters; they wrap naturally and ignore flushes
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy_in) begin
      if (hit_accept)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_accept) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign _hit_cnt  = hit_cnt_q;
  assign _miss_cnt = miss_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = hit_accept ^ miss_accept;
  assign _hit_cnt     = '0;
  assign _miss_cnt    = '0;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// tb/tb_inst_cache.sv - scoreboard bench for inst_cache with a behavioural cache model
module tb_inst_cache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_ready;
  logic [31:0] if_inst;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_valid;
  logic [31:0] mc_data;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  inst_cache dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    ._clear   (clear),
    ._if_req  (if_req),
    ._if_pc   (if_pc),
    ._if_ready(if_ready),
    ._if_inst (if_inst),
    ._mc_req  (mc_req),
    ._mc_addr (mc_addr),
    ._mc_valid(mc_valid),
    ._mc_data (mc_data),
    ._hit_cnt (hit_cnt),
    ._miss_cnt(miss_cnt)
  );

  always #5 clk_in = ~clk_in;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  // Reference model: one entry per line, keyed by pc[5:2], tag pc[31:6]
  bit          m_valid[16];
  logic [25:0] m_tag[16];
  int          m_hits = 0;
  int          m_misses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h0000_1004) return 32'h0010_0093;
    if (a == 32'h0000_1044) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[pc[5:2]] && (m_tag[pc[5:2]] == pc[31:6]);
  endfunction

  task automatic model_fill(input logic [31:0] pc);
    m_valid[pc[5:2]] = 1'b1;
    m_tag[pc[5:2]]   = pc[31:6];
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_hit_cnt"},  hit_cnt,  STATS ? m_hits : 0);
    chk({tag, "_miss_cnt"}, miss_cnt, STATS ? m_misses : 0);
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation
  initial begin
    logic        prev_ready;
    logic [31:0] e;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk_in);
      if (rst_in && if_ready) begin
        chk("if_ready_pulse", {31'b0, prev_ready & if_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", {31'b0, if_ready}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("if_inst", if_inst, e);
        end
      end
      prev_ready = if_ready;
    end
  end

  // Issue one fetch and act as memory; lat = negedges between seeing _mc_req and _mc_valid
  task automatic do_fetch(input logic [31:0] pc, input int lat, input int stall);
    bit          exp_hit;
    bit          done;
    bit          seen_req;
    bit          responded;
    int          cycles;
    int          wait_cnt;
    logic [31:0] word;
    exp_hit   = model_hit(pc);
    done      = 0;
    seen_req  = 0;
    responded = 0;
    cycles    = 0;
    wait_cnt  = 0;
    word      = {pc[31:2], 2'b00};
    if (exp_hit) m_hits++;
    else         m_misses++;
    exp_q.push_back(memval(word));
    if_req = 1'b1;
    if_pc  = pc;
    while (!done && cycles < 60) begin
      @(negedge clk_in);
      cycles++;
      mc_valid = 1'b0;
      if (if_ready) begin
        done = 1;
      end else if (mc_req && !seen_req) begin
        seen_req = 1;
        chk("mc_addr", mc_addr, word);
        if (stall > 0) begin
          rdy_in = 1'b0;
          for (int s = 0; s < stall; s++) begin
            @(negedge clk_in);
            cycles++;
            chk("stall_mc_req", {31'b0, mc_req}, 32'd1);
            chk("stall_mc_addr", mc_addr, word);
            chk("stall_if_ready", {31'b0, if_ready}, 32'd0);
          end
          rdy_in = 1'b1;
        end
        wait_cnt = lat;
      end
      if (seen_req && !responded && !done) begin
        if (wait_cnt == 0) begin
          mc_valid  = 1'b1;
          mc_data   = memval(mc_addr);
          responded = 1;
        end else begin
          wait_cnt--;
        end
      end
    end
    if_req   = 1'b0;
    mc_valid = 1'b0;
    chk("latency", cycles, exp_hit ? 1 : 2 + lat + stall);
    if (exp_hit) chk("hit_no_mc_req", {31'b0, seen_req}, 32'd0);
    if (!done) exp_q.delete();
    if (!exp_hit) model_fill(pc);
    @(negedge clk_in);
  endtask

  task automatic start_miss(input logic [31:0] pc);
    int n;
    n = 0;
    m_misses++;
    if_req = 1'b1;
    if_pc  = pc;
    do begin
      @(negedge clk_in);
      n++;
    end while (!mc_req && n < 10);
    chk("start_miss_mc_req", {31'b0, mc_req}, 32'd1);
  endtask

  initial begin
    logic [31:0] pc;
    rst_in   = 1'b0;
    rdy_in   = 1'b1;
    clear    = 1'b0;
    if_req   = 1'b0;
    if_pc    = '0;
    mc_valid = 1'b0;
    mc_data  = '0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);

    chk("rst_if_ready", {31'b0, if_ready}, 32'd0);
    chk("rst_if_inst",  if_inst,  32'd0);
    chk("rst_mc_req",   {31'b0, mc_req}, 32'd0);
    chk("rst_mc_addr",  mc_addr,  32'd0);
    chk_counters("rst");

    // Cold miss, then hit on the same word with a different byte offset
    do_fetch(32'h0000_1004, 3, 0);
    chk_counters("cold");
    do_fetch(32'h0000_1006, 0, 0);
    chk_counters("hit");

    // Same index, different tag: fill evicts the old line
    do_fetch(32'h0000_1044, 2, 0);
    do_fetch(32'h0000_1004, 1, 0);
    chk_counters("conflict");

    // Flush while a miss is outstanding, followed by a stale response
    start_miss(32'h0000_2000);
    clear  = 1'b1;
    if_req = 1'b0;
    @(negedge clk_in);
    clear = 1'b0;
    chk("clr_mc_req", {31'b0, mc_req}, 32'd0);
    chk("clr_if_ready", {31'b0, if_ready}, 32'd0);
    @(negedge clk_in);
    mc_valid = 1'b1;
    mc_data  = 32'hBAD0_0001;
    @(negedge clk_in);
    mc_valid = 1'b0;
    chk("stale_if_ready", {31'b0, if_ready}, 32'd0);
    @(negedge clk_in);
    chk("stale_if_ready2", {31'b0, if_ready}, 32'd0);
    do_fetch(32'h0000_2000, 1, 0);

    // Flush coincident with the memory response still fills the line
    start_miss(32'h0000_3008);
    mc_valid = 1'b1;
    mc_data  = memval(mc_addr);
    clear    = 1'b1;
    if_req   = 1'b0;
    @(negedge clk_in);
    mc_valid = 1'b0;
    clear    = 1'b0;
    chk("clrv_if_ready", {31'b0, if_ready}, 32'd0);
    chk("clrv_mc_req", {31'b0, mc_req}, 32'd0);
    model_fill(32'h0000_3008);
    @(negedge clk_in);
    do_fetch(32'h0000_3008, 0, 0);
    chk_counters("clear");

    // Global stall in the middle of a miss
    do_fetch(32'h0000_5010, 2, 5);
    chk_counters("stall");

    // Randomized fetches over a small address window to force hits and conflicts
    for (int i = 0; i < 60; i++) begin
      pc = 32'h0000_8000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)
           | $urandom_range(0, 3);
      do_fetch(pc, $urandom_range(0, 4), ($urandom_range(0, 7) == 0) ? 2 : 0);
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
    end
    chk_counters("random");

    // Asynchronous reset in the middle of a miss
    start_miss(32'h0000_6000);
    #2;
    rst_in = 1'b0;
    #1;
    chk("arst_mc_req", {31'b0, mc_req}, 32'd0);
    chk("arst_mc_addr", mc_addr, 32'd0);
    if_req = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
    @(negedge clk_in);
    chk_counters("arst");
    do_fetch(32'h0000_1006, 1, 0);
    chk_counters("post_rst");

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
